// File: rtl/cve2_register_file_mp_if.sv
// Register-file access bundle: read ports, two write ports, scoreboard set and wipe control.
// Parameters must match those of the register file instance it connects to.
interface cve2_register_file_mp_if #(
  parameter int unsigned NumReadPorts = 2,
  parameter int unsigned DataWidth    = 32
);
  logic                                   test_en;
  logic [NumReadPorts-1:0][4:0]           raddr;
  logic [NumReadPorts-1:0][DataWidth-1:0] rdata;
  logic [NumReadPorts-1:0]                rbusy;
  logic [4:0]                             waddr_a;
  logic [DataWidth-1:0]                   wdata_a;
  logic                                   we_a;
  logic [4:0]                             waddr_b;
  logic [DataWidth-1:0]                   wdata_b;
  logic                                   we_b;
  logic                                   sb_set;
  logic [4:0]                             sb_addr;
  logic                                   wipe_req;
  logic                                   wipe_busy;
  logic                                   wipe_done;

  modport master (
    output test_en, raddr, waddr_a, wdata_a, we_a, waddr_b, wdata_b, we_b,
           sb_set, sb_addr, wipe_req,
    input  rdata, rbusy, wipe_busy, wipe_done
  );

  modport slave (
    input  test_en, raddr, waddr_a, wdata_a, we_a, waddr_b, wdata_b, we_b,
           sb_set, sb_addr, wipe_req,
    output rdata, rbusy, wipe_busy, wipe_done
  );
endinterface

// File: rtl/cve2_register_file_mp.sv
// Flip-flop RISC-V register file: N read ports, two write ports, optional write bypass,
// pending-write scoreboard and a sequential secure-wipe engine.

module cve2_register_file_mp_rport #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter int unsigned          NUM_WORDS   = 32,
  parameter int                   AW          = 5,
  parameter bit                   WriteBypass = 1'b1
) (
  input  logic [4:0]                          raddr,
  input  logic [NUM_WORDS-1:0][DataWidth-1:0] mem,
  input  logic [NUM_WORDS-1:0]                busy,
  input  logic                                we_a_ok,
  input  logic [AW-1:0]                       wa_idx,
  input  logic [DataWidth-1:0]                wdata_a,
  input  logic                                we_b_ok,
  input  logic [AW-1:0]                       wb_idx,
  input  logic [DataWidth-1:0]                wdata_b,
  output logic [DataWidth-1:0]                rdata,
  output logic                                rbusy
);
  logic [AW-1:0] idx;
  logic          ok;

  assign idx   = raddr[AW-1:0];
  assign ok    = !(RV32E && raddr[4]) && (idx != '0);
  assign rbusy = ok & busy[idx];

  // we_*_ok already exclude x0, out-of-range addresses and the wipe phase
  always_comb begin
    rdata = mem[idx];
    if (WriteBypass && we_a_ok && (wa_idx == idx))      rdata = wdata_a;
    else if (WriteBypass && we_b_ok && (wb_idx == idx)) rdata = wdata_b;
    if (!ok) rdata = WordZeroVal;
  end
endmodule

module cve2_register_file_mp #(
  parameter bit                   RV32E        = 1'b0,
  parameter int unsigned          DataWidth    = 32,
  parameter logic [DataWidth-1:0] WordZeroVal  = '0,
  parameter int unsigned          NumReadPorts = 2,
  parameter bit                   WriteBypass  = 1'b1,
  parameter bit                   ScoreboardEn = 1'b1
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  cve2_register_file_mp_if.slave  bus
);
  localparam int unsigned NUM_WORDS = RV32E ? 16 : 32;
  localparam int          AW        = RV32E ? 4 : 5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WIPE = 1'b1;

  logic [NUM_WORDS-1:0][DataWidth-1:0] mem;
  logic [NUM_WORDS-1:0]                busy;
  logic [0:0]                          state;
  logic [AW-1:0]                       cnt;
  logic                                wipe_done_q;
  logic                                idle;
  logic                                we_a_ok, we_b_ok, clr_ok, sb_ok;
  logic [AW-1:0]                       wa_idx, wb_idx, sb_idx;
  logic                                unused_test_en;

  function automatic logic addr_ok(input logic [4:0] a);
    return !(RV32E && a[4]);
  endfunction

  assign unused_test_en = bus.test_en;
  assign idle   = (state == ST_IDLE);
  assign wa_idx = bus.waddr_a[AW-1:0];
  assign wb_idx = bus.waddr_b[AW-1:0];
  assign sb_idx = bus.sb_addr[AW-1:0];

  assign we_a_ok = bus.we_a & idle & addr_ok(bus.waddr_a) & (wa_idx != '0);
  assign we_b_ok = bus.we_b & idle & addr_ok(bus.waddr_b) & (wb_idx != '0);
  assign clr_ok  = bus.we_b & idle & addr_ok(bus.waddr_b);
  assign sb_ok   = ScoreboardEn & bus.sb_set & idle & addr_ok(bus.sb_addr) & (sb_idx != '0);

  // Word 0 is only ever loaded by reset, so it stays at WordZeroVal
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem <= {NUM_WORDS{WordZeroVal}};
    end else begin
      for (int w = 1; w < NUM_WORDS; w++) begin
        if (!idle && (cnt == AW'(w)))           mem[w] <= WordZeroVal;
        else if (we_a_ok && (wa_idx == AW'(w))) mem[w] <= bus.wdata_a;
        else if (we_b_ok && (wb_idx == AW'(w))) mem[w] <= bus.wdata_b;
      end
    end
  end

  generate
    if (ScoreboardEn) begin : g_sb
      // set has priority over a same-cycle clear from port B
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          busy <= '0;
        end else begin
          for (int w = 1; w < NUM_WORDS; w++) begin
            if (!idle && (cnt == AW'(w)))         busy[w] <= 1'b0;
            else if (sb_ok && (sb_idx == AW'(w))) busy[w] <= 1'b1;
            else if (clr_ok && (wb_idx == AW'(w))) busy[w] <= 1'b0;
          end
        end
      end
    end else begin : g_no_sb
      assign busy = '0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      cnt         <= AW'(1);
      wipe_done_q <= 1'b0;
    end else begin
      wipe_done_q <= 1'b0;
      case (state)
        ST_IDLE: if (bus.wipe_req) state <= ST_WIPE;
        default: begin
          if (cnt == AW'(NUM_WORDS - 1)) begin
            state       <= ST_IDLE;
            cnt         <= AW'(1);
            wipe_done_q <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
      endcase
    end
  end

  assign bus.wipe_busy = !idle;
  assign bus.wipe_done = wipe_done_q;

  logic [NumReadPorts-1:0][DataWidth-1:0] rdata;
  logic [NumReadPorts-1:0]                rbusy;

  generate
    for (genvar p = 0; p < NumReadPorts; p++) begin : g_rport
      cve2_register_file_mp_rport #(
        .RV32E       (RV32E),
        .DataWidth   (DataWidth),
        .WordZeroVal (WordZeroVal),
        .NUM_WORDS   (NUM_WORDS),
        .AW          (AW),
        .WriteBypass (WriteBypass)
      ) u_rport (
        .raddr   (bus.raddr[p]),
        .mem     (mem),
        .busy    (busy),
        .we_a_ok (we_a_ok),
        .wa_idx  (wa_idx),
        .wdata_a (bus.wdata_a),
        .we_b_ok (we_b_ok),
        .wb_idx  (wb_idx),
        .wdata_b (bus.wdata_b),
        .rdata   (rdata[p]),
        .rbusy   (rbusy[p])
      );
    end
  endgenerate

  assign bus.rdata = rdata;
  assign bus.rbusy = rbusy;
endmodule

// File: tb/tb_cve2_register_file_mp.sv
// Randomized self-checking bench: a behavioural array model of the register file,
// plus directed checks for bypass, scoreboard, x0, RV32E aliasing and the wipe engine.
module tb_cve2_register_file_mp;
  localparam int NRP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cve2_register_file_mp_if #(.NumReadPorts(NRP), .DataWidth(32)) bus ();
  cve2_register_file_mp_if #(.NumReadPorts(2),   .DataWidth(32)) bus_e ();

  cve2_register_file_mp #(.NumReadPorts(NRP)) dut (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus)
  );
  cve2_register_file_mp #(.RV32E(1'b1), .NumReadPorts(2)) dut_e (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus_e)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_reg [32];
  bit          m_busy[32];
  bit          m_wipe;
  int          m_pos;
  bit          m_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
    m_wipe = 1'b0; m_pos = 1; m_done = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return '0;
    if (!m_wipe && bus.we_a && bus.waddr_a == a) return bus.wdata_a;
    if (!m_wipe && bus.we_b && bus.waddr_b == a) return bus.wdata_b;
    return m_reg[a];
  endfunction

  task automatic model_tick();
    m_done = 1'b0;
    if (m_wipe) begin
      m_reg[m_pos] = '0; m_busy[m_pos] = 1'b0;
      if (m_pos == 31) begin m_wipe = 1'b0; m_pos = 1; m_done = 1'b1; end
      else m_pos++;
    end else begin
      if (bus.wipe_req) m_wipe = 1'b1;
      if (bus.we_b && bus.waddr_b != 0) m_reg[bus.waddr_b] = bus.wdata_b;
      if (bus.we_a && bus.waddr_a != 0) m_reg[bus.waddr_a] = bus.wdata_a;
      if (bus.we_b) m_busy[bus.waddr_b] = 1'b0;
      if (bus.sb_set && bus.sb_addr != 0) m_busy[bus.sb_addr] = 1'b1;
    end
  endtask

  task automatic check_outs();
    for (int p = 0; p < NRP; p++) begin
      chk($sformatf("rdata[%0d] x%0d", p, bus.raddr[p]), bus.rdata[p], exp_rd(bus.raddr[p]));
      chk($sformatf("rbusy[%0d] x%0d", p, bus.raddr[p]), bus.rbusy[p],
          (bus.raddr[p] != 0) && m_busy[bus.raddr[p]]);
    end
    chk("wipe_busy", bus.wipe_busy, m_wipe);
    chk("wipe_done", bus.wipe_done, m_done);
  endtask

  task automatic sync();
    @(posedge clk); model_tick(); #1;
  endtask

  task automatic step();
    #1; check_outs(); sync();
  endtask

  task automatic idle_in();
    bus.test_en = 1'b0; bus.raddr = '0;
    bus.we_a = 1'b0; bus.waddr_a = '0; bus.wdata_a = '0;
    bus.we_b = 1'b0; bus.waddr_b = '0; bus.wdata_b = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0; bus.wipe_req = 1'b0;
    bus_e.test_en = 1'b0; bus_e.raddr = '0;
    bus_e.we_a = 1'b0; bus_e.waddr_a = '0; bus_e.wdata_a = '0;
    bus_e.we_b = 1'b0; bus_e.waddr_b = '0; bus_e.wdata_b = '0;
    bus_e.sb_set = 1'b0; bus_e.sb_addr = '0; bus_e.wipe_req = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    for (int p = 0; p < NRP; p++) bus.raddr[p] = a;
    #1; check_outs(); chk(tag, bus.rdata[0], exp); sync();
  endtask

  task automatic fill_regs();
    idle_in();
    for (int i = 1; i < 32; i++) begin
      bus.we_a = 1'b1; bus.waddr_a = 5'(i); bus.wdata_a = 32'(i); step();
    end
    idle_in();
  endtask

  // Pulses wipe_req and counts cycles with wipe_busy high, writing on port A throughout
  task automatic run_wipe(input string tag);
    int n;
    idle_in(); bus.wipe_req = 1'b1; step(); bus.wipe_req = 1'b0;
    n = 0;
    while (bus.wipe_busy && n < 100) begin
      bus.we_a = 1'b1; bus.waddr_a = 5'($urandom_range(1, 31)); bus.wdata_a = $urandom();
      step(); n++;
    end
    idle_in();
    chk({tag, "_len"}, 64'(n), 64'd31);
    #1; chk({tag, "_done_pulse"}, bus.wipe_done, 1'b1); check_outs(); sync();
    #1; chk({tag, "_done_clear"}, bus.wipe_done, 1'b0); sync();
    for (int a = 0; a < 32; a++) rd_chk({tag, "_zero"}, 5'(a), 32'h0);
  endtask

  initial begin
    model_reset();
    idle_in();

    // Reset: every address reads zero, not busy, no wipe
    for (int a = 0; a < 32; a++) rd_chk("reset_read", 5'(a), 32'h0);
    chk("reset_wipe_busy", bus.wipe_busy, 1'b0);
    @(negedge clk); rst_n = 1'b1; sync();

    // A and B to the same register: A wins in bypass and in storage
    idle_in();
    bus.we_a = 1'b1; bus.waddr_a = 5'd5; bus.wdata_a = 32'hDEAD_BEEF;
    bus.we_b = 1'b1; bus.waddr_b = 5'd5; bus.wdata_b = 32'h0000_1234;
    bus.raddr[0] = 5'd5;
    #1; chk("ab_bypass", bus.rdata[0], 32'hDEAD_BEEF); step();
    idle_in(); rd_chk("ab_stored", 5'd5, 32'hDEAD_BEEF);

    // Scoreboard set, clear by B, and simultaneous set+clear
    bus.sb_set = 1'b1; bus.sb_addr = 5'd7; step();
    idle_in(); bus.raddr[0] = 5'd7; #1; chk("sb_set", bus.rbusy[0], 1'b1);
    bus.we_b = 1'b1; bus.waddr_b = 5'd7; bus.wdata_b = 32'h55; step();
    idle_in(); bus.raddr[0] = 5'd7; #1;
    chk("sb_clear", bus.rbusy[0], 1'b0); chk("sb_clear_data", bus.rdata[0], 32'h55);
    bus.sb_set = 1'b1; bus.sb_addr = 5'd7;
    bus.we_b = 1'b1; bus.waddr_b = 5'd7; bus.wdata_b = 32'h66; step();
    idle_in(); bus.raddr[0] = 5'd7; #1; chk("sb_set_wins", bus.rbusy[0], 1'b1); step();

    // x0 is immutable and never busy
    bus.we_a = 1'b1; bus.waddr_a = 5'd0; bus.wdata_a = 32'hFFFF_FFFF;
    bus.we_b = 1'b1; bus.waddr_b = 5'd0; bus.wdata_b = 32'hFFFF_FFFF;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd0; step();
    idle_in(); bus.raddr[0] = 5'd0; #1;
    chk("x0_data", bus.rdata[0], 32'h0); chk("x0_busy", bus.rbusy[0], 1'b0); step();

    // RV32E: upper addresses do not alias onto x0..x15
    bus_e.we_a = 1'b1; bus_e.waddr_a = 5'd4; bus_e.wdata_a = 32'h0000_AAAA; sync();
    bus_e.waddr_a = 5'd20; bus_e.wdata_a = 32'h0000_5555;
    bus_e.sb_set = 1'b1; bus_e.sb_addr = 5'd20; sync();
    idle_in(); bus_e.raddr[0] = 5'd4; bus_e.raddr[1] = 5'd20; #1;
    chk("e_x4_kept", bus_e.rdata[0], 32'h0000_AAAA);
    chk("e_x4_busy", bus_e.rbusy[0], 1'b0);
    chk("e_x20_data", bus_e.rdata[1], 32'h0);
    chk("e_x20_busy", bus_e.rbusy[1], 1'b0);
    sync();

    // Random traffic with collision bias and occasional wipes
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NRP; p++) bus.raddr[p] = 5'($urandom());
      bus.we_a = 1'($urandom()); bus.waddr_a = 5'($urandom()); bus.wdata_a = $urandom();
      bus.we_b = 1'($urandom()); bus.waddr_b = 5'($urandom()); bus.wdata_b = $urandom();
      if ($urandom_range(0, 3) == 0) bus.waddr_b = bus.waddr_a;
      if ($urandom_range(0, 2) == 0) bus.raddr[0] = bus.waddr_a;
      if ($urandom_range(0, 2) == 0) bus.raddr[1] = bus.waddr_b;
      bus.sb_set = ($urandom_range(0, 3) == 0); bus.sb_addr = 5'($urandom());
      if ($urandom_range(0, 2) == 0) bus.sb_addr = bus.waddr_b;
      bus.wipe_req = ($urandom_range(0, 79) == 0);
      step();
    end
    idle_in();
    for (int c = 0; c < 40 && m_wipe; c++) step();
    step();

    // Full wipe after filling every register
    fill_regs();
    run_wipe("wipe");

    // Reset in the middle of a wipe, then a fresh wipe runs to completion
    fill_regs();
    bus.wipe_req = 1'b1; step(); bus.wipe_req = 1'b0;
    for (int c = 0; c < 10; c++) step();
    rst_n = 1'b0; model_reset(); #1;
    chk("rst_mid_wipe_busy", bus.wipe_busy, 1'b0);
    check_outs();
    @(negedge clk); rst_n = 1'b1; sync();
    for (int a = 0; a < 32; a++) rd_chk("rst_mid_zero", 5'(a), 32'h0);
    fill_regs();
    run_wipe("rewipe");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
